// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants and the fetch entry type used by fetch and decode.
// Contents: NOP_INST (addi x0,x0,0), RESET_PC, fetch_entry_t {pc, inst}.
package cpu_pkg;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam logic [63:0] RESET_PC = 64'h80000000;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between fetch, the fetch queue and decode.
// Signals: flush, in_valid/in_ready/in_pc/in_inst (fetch side),
//          out_valid/out_ready/out_pc/out_inst (decode side), count (occupancy).
// Modports: master = fetch/decode/redirect driver, slave = the queue.
interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    localparam int PTR_W = $clog2(DEPTH);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [PTR_W:0]    count;
    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x fetch_entry_t register array for the fetch queue.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
// Contents are not reset.
import cpu_pkg::*;
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_entry_t     rdata
);
    fetch_entry_t mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, inst} between instruction fetch and decode.
// Ports: clk, rst (sync, active-high); q (fetch_queue_if.slave): flush,
//        in_valid/in_ready/in_pc/in_inst, out_valid/out_ready/out_pc/out_inst, count.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards in_* to out_*
// in the same cycle; otherwise minimum latency is one cycle.
import cpu_pkg::*;
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst,
    fetch_queue_if.slave q
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             empty, full, byp, pop, write;
    fetch_entry_t     rdata, wdata;
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = empty & q.in_valid & ~q.flush;
`else
    assign byp = 1'b0;
`endif
    // A bypassed entry consumed the same cycle never touches storage.
    assign write = q.in_valid & ~full & ~(byp & q.out_ready);
    assign pop   = ~empty & q.out_ready;
    assign wdata = '{pc: 64'(q.in_pc), inst: 32'(q.in_inst)};
    assign q.in_ready  = ~full;
    assign q.out_valid = ~empty | byp;
    assign q.count     = cnt;
    assign q.out_pc    = byp ? q.in_pc : empty ? '0 : PC_W'(rdata.pc);
    assign q.out_inst  = byp ? q.in_inst : empty ? INST_W'(NOP_INST) : INST_W'(rdata.inst);
    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (write & ~rst & ~q.flush),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
    always_ff @(posedge clk)
        if (rst || q.flush) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            cnt    <= cnt + {{PTR_W{1'b0}}, write} - {{PTR_W{1'b0}}, pop};
            wr_ptr <= wr_ptr + PTR_W'(write);
            rd_ptr <= rd_ptr + PTR_W'(pop);
        end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized self-checking bench for fetch_queue.
import cpu_pkg::*;
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    fetch_entry_t model_q[$];
    logic [63:0] last_pc;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit byp_now();
        return BYP && bus.in_valid && !bus.flush && model_q.size() == 0;
    endfunction

    task automatic check_all(input string tag);
        bit bp = byp_now();
        check({tag, ".count"}, 64'(bus.count), 64'(model_q.size()));
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(model_q.size() < DEPTH));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(model_q.size() != 0 || bp));
        check({tag, ".out_pc"}, bus.out_pc,
              model_q.size() != 0 ? model_q[0].pc : bp ? bus.in_pc : 64'h0);
        check({tag, ".out_inst"}, 64'(bus.out_inst),
              64'(model_q.size() != 0 ? model_q[0].inst : bp ? bus.in_inst : NOP_INST));
    endtask

    // Reference update from the queue rules, then advance one clock and compare.
    task automatic tick(input string tag);
        bit bp = byp_now();
        bit can_push = bus.in_valid && model_q.size() < DEPTH;
        bit can_pop = model_q.size() != 0 && bus.out_ready;
        if (rst || bus.flush) model_q.delete();
        else begin
            if (can_pop) void'(model_q.pop_front());
            if (can_push && !(bp && bus.out_ready)) model_q.push_back('{pc: bus.in_pc, inst: bus.in_inst});
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input logic [31:0] inst, input bit rdy);
        bus.in_valid = v;
        bus.in_pc = pc;
        bus.in_inst = inst;
        bus.out_ready = rdy;
    endtask

    initial begin
        bus.flush = 1'b0;
        drive(0, 64'h0, 32'h0, 0);
        // 1: reset then idle
        @(posedge clk); #1;
        model_q.delete();
        tick("reset_a");
        tick("reset_b");
        rst = 1'b0;
        tick("idle");
        check("idle_nop", 64'(bus.out_inst), 64'h13);
        // 2: fill to full, fifth push dropped
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h80000000 + 64'(4 * i), 32'h93 + 32'(i * 32'h100), 0);
            tick("fill");
        end
        check("full_count", 64'(bus.count), 64'd4);
        check("full_ready", 64'(bus.in_ready), 64'd0);
        drive(1, 64'h80000010, 32'h493, 0);
        tick("fifth_push");
        check("fifth_count", 64'(bus.count), 64'd4);
        // 3: drain in order
        drive(0, 64'h0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_pc", bus.out_pc, 64'h80000000 + 64'(4 * i));
            tick("drain");
        end
        check("drained_valid", 64'(bus.out_valid), 64'd0);
        // 4: steady push/pop at count 2 across wrap
        for (int i = 0; i < 2; i++) begin
            drive(1, 64'h80001000 + 64'(4 * i), 32'h13, 0);
            tick("pre_fill");
        end
        last_pc = 64'h80000FFC;
        for (int i = 0; i < 10; i++) begin
            drive(1, 64'h80001008 + 64'(4 * i), 32'h13, 1);
            #1;
            check("stream_step", bus.out_pc, last_pc + 64'd4);
            last_pc = bus.out_pc;
            tick("stream");
            check("stream_count", 64'(bus.count), 64'd2);
        end
        // 5: flush with concurrent push
        drive(1, 64'h80002000, 32'h13, 0);
        tick("to_three");
        drive(1, 64'h80000100, 32'h113, 0);
        bus.flush = 1'b1;
        tick("flush");
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        bus.flush = 1'b0;
        drive(1, 64'h80000200, 32'h213, 0);
        tick("after_flush_push");
        drive(0, 64'h0, 32'h0, 0);
        #1;
        check("after_flush_pc", bus.out_pc, 64'h80000200);
        // 6: reset mid-operation with push and pop
        for (int i = 0; i < 2; i++) begin
            drive(1, 64'h80003000 + 64'(4 * i), 32'h13, 0);
            tick("to_three_b");
        end
        drive(1, 64'h80004000, 32'h13, 1);
        rst = 1'b1;
        tick("mid_reset");
        check("mid_reset_count", 64'(bus.count), 64'd0);
        check("mid_reset_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        drive(0, 64'h0, 32'h0, 0);
        tick("post_reset");
`ifdef FETCH_QUEUE_BYPASS_EN
        drive(1, 64'h80005000, 32'h513, 1);
        #1;
        check("byp_valid", 64'(bus.out_valid), 64'd1);
        check("byp_pc", bus.out_pc, 64'h80005000);
        tick("byp");
        check("byp_count", 64'(bus.count), 64'd0);
`endif
        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, $urandom(), $urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 30) == 0);
            rst = ($urandom_range(0, 60) == 0);
            tick("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small FIFO of fetched {pc, inst} pairs, placed directly downstream of the instruction-fetch stage and upstream of decode.
- Decouples fetch from decode stalls: its backpressure (in_ready low) is the fetch stage's bubble input.
- Emptied in one cycle by flush when execute/memory redirects the PC (jal, jalr, taken branch, trap to mtvec).

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- PC_W, 64, PC width
- INST_W, 32, instruction width
- PTR_W, $clog2(DEPTH), derived pointer width; not overridable

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  reset; synchronous, active-high
- flush  input  1  discard all entries (pipeline redirect)
- in_valid  input  1  fetch presents a valid pc/inst this cycle
- in_ready  output  1  queue can accept; inverted, this is fetch's bubble
- in_pc  input  PC_W  PC of the fetched instruction
- in_inst  input  INST_W  fetched instruction word
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  PC_W  head PC
- out_inst  output  INST_W  head instruction
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage
  - Circular buffer of DEPTH entries with head pointer rd_ptr, tail pointer wr_ptr (PTR_W bits each) and occupancy cnt (PTR_W+1 bits).
  - Pointers wrap modulo DEPTH; count = cnt.
- Handshakes
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (cnt != DEPTH). It does not depend on out_ready: no combinational ready path through the queue.
  - out_valid = (cnt != 0).
- Output data
  - out_pc/out_inst come from the entry at rd_ptr when out_valid is 1.
  - When empty, out_inst = 32'h00000013 (NOP) and out_pc = 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). No same-cycle bypass unless the optional feature is compiled in.
- Occupancy update per cycle
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged and both pointers advance. Legal at any occupancy 1..DEPTH-1.
- Full: in_ready = 0; in_valid is ignored and nothing is written. Fetch must hold its PC while in_ready is 0.
- Empty: out_valid = 0; out_ready is ignored.
- Flush
  - Takes effect at the next edge: cnt = 0, rd_ptr = wr_ptr = 0.
  - Overrides any push or pop in the same cycle; the concurrent in_* data is discarded.
  - out_valid is 0 the cycle after flush.
- Reset
  - At a posedge with rst = 1: cnt = 0 and both pointers = 0, so out_valid = 0, in_ready = 1 and count = 0.
  - Reset overrides flush, push and pop.
  - Storage contents are not reset.
  - Reset mid-operation drops all entries.
- Priority: rst > flush > push/pop.
- No state machine beyond the pointers and occupancy counter.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When cnt == 0 and in_valid = 1, out_valid = 1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - If out_ready = 1 that cycle, the entry is consumed without being written (cnt stays 0).
  - If out_ready = 0, it is written normally.
  - Flush in the same cycle forces out_valid = 0.
- Undefined: one-cycle minimum latency as described above.

Decomposition:
- Shared package (cpu_pkg), holding:
  - NOP_INST = 32'h00000013
  - RESET_PC = 64'h80000000
  - typedef fetch_entry_t {pc[63:0], inst[31:0]}, which decode also uses.
- One natural sub-module, fetch_queue_mem:
  - DEPTH x fetch_entry_t register array.
  - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - Pointer and count control stays in fetch_queue.

Test Plan:
1. Reset then idle: rst high for 2 cycles, then in_valid = 0 -> out_valid = 0, in_ready = 1, count = 0, out_inst = 0x00000013, out_pc = 0.
2. Fill to full:
   - Stimulus: out_ready = 0; push pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C with inst 0x00000093..0x00000393.
   - count reaches 4 and in_ready = 0.
   - A fifth push (pc 0x80000010) is dropped and count stays 4.
3. Drain in order: after scenario 2, out_ready = 1 for 4 cycles -> out_pc = 0x80000000, 0x80000004, 0x80000008, 0x8000000C in order; then out_valid = 0 and count = 0.
4. Simultaneous push/pop and wrap-around:
   - Stimulus: hold count = 2 and push/pop every cycle for 10 cycles with incrementing PCs.
   - count stays 2 throughout.
   - Output PCs are strictly sequential with step 4 across pointer wrap.
5. Flush with concurrent push: count = 3, flush = 1 and push pc 0x80000100 in the same cycle -> next cycle count = 0, out_valid = 0. The following push of 0x80000200 appears as out_pc one cycle later.
6. Reset mid-operation: count = 3, rst = 1 together with push and pop -> next cycle count = 0, in_ready = 1. Bypass builds: empty queue with in_valid = 1 and out_ready = 1 gives out_valid = 1 in the same cycle and count stays 0.
